fp_mult_seq: RTL and testbench

//  Multi-cycle sequencer for the IEEE-754 single-precision multiplier.
//  - Accepts an operand pair over a valid/ready handshake.
//  - Drives the add_exp exponent adder, then runs an iterative 24-step shift-add mantissa multiply.
//  - Normalises, rounds and returns the packed result with overflow/underflow flags.
//  - Sits between the operand source and the result consumer; one operation in flight at a time.

---
 rtl/fp_mult_pkg.sv | 29 ++
 rtl/add_exp.sv | 14 +
 rtl/fp_man_mul_iter.sv | 64 ++++++
 rtl/fp_mult_seq.sv | 210 +++++++++++++++++++++
 tb/tb_fp_mult_seq.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the sequential IEEE-754 single-precision multiplier.
// FP_MULT_RNE_EN selects round-to-nearest-even; otherwise results truncate toward zero.
package fp_mult_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int BIAS   = 127;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;

    localparam logic [31:0]      QNAN    = 32'h7FC00000;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    // Low product bits are only exported when rounding needs guard/sticky.
`ifdef FP_MULT_RNE_EN
    localparam int P_LO = 0;
`else
    localparam int P_LO = MAN_W;
`endif

    typedef enum logic [2:0] {
        IDLE,
        EXP,
        MUL,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/add_exp.sv
// Ripple exponent adder: {cout, sum} = a + b + cin.
module add_exp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/fp_man_mul_iter.sv
// Iterative LSB-first shift-add significand multiplier, one partial product per cycle.
module fp_man_mul_iter
    import fp_mult_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SIG_W-1:0]       a_sig,
    input  logic [SIG_W-1:0]       b_sig,
    output logic                   done,
    output logic [PROD_W-1:P_LO]   prod
);

    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [PROD_W-1:0] prod_q, prod_d;
    logic [SIG_W-1:0]  mplr_q, mplr_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              run_q, run_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        mplr_d  = mplr_q;
        cnt_d   = '0;
        run_d   = run_q;
        if (start) begin
            mcand_d = {{SIG_W{1'b0}}, a_sig};
            prod_d  = '0;
            mplr_d  = b_sig;
            run_d   = 1'b1;
        end else if (run_q) begin
            if (mplr_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            if (done) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    assign done = run_q && (cnt_q == 5'(SIG_W - 1));
    assign prod = prod_q[PROD_W-1:P_LO];

endmodule

// File: rtl/fp_mult_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier with valid/ready handshake.
// Build with FP_MULT_RNE_EN for round-to-nearest-even; default truncates.
module fp_mult_seq
    import fp_mult_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf,
    output logic        busy
);

    localparam logic signed [9:0] BIAS_S = 10'(BIAS);

    state_t state_q, state_d;

    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic signed [9:0]  e_q, e_d;
    logic               sign_q, sign_d;
    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               out_valid_q, out_valid_d;

    logic [EXP_W-1:0]   exp_sum;
    logic               exp_cout;
    logic               mul_start;
    logic               mul_done;
    logic [PROD_W-1:P_LO] prod;

    add_exp #(
        .W    (EXP_W)
    ) u_add_exp (
        .a    (a_q[30:23]),
        .b    (b_q[30:23]),
        .cin  (1'b0),
        .sum  (exp_sum),
        .cout (exp_cout)
    );

    fp_man_mul_iter u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a_sig ({1'b1, a_q[22:0]}),
        .b_sig ({1'b1, b_q[22:0]}),
        .done  (mul_done),
        .prod  (prod)
    );

    // Zero / Inf / NaN operands bypass the multiply entirely.
    logic        a_max, b_max, a_zero, b_zero, special;
    logic        s_ab;
    logic [31:0] spec_res;

    always_comb begin
        a_max   = a_q[30:23] == EXP_MAX;
        b_max   = b_q[30:23] == EXP_MAX;
        a_zero  = a_q[30:23] == '0;
        b_zero  = b_q[30:23] == '0;
        special = a_max | b_max | a_zero | b_zero;
        s_ab    = a_q[31] ^ b_q[31];
        if (a_max | b_max) begin
            spec_res = (a_zero | b_zero) ? QNAN : {s_ab, EXP_MAX, 23'b0};
        end else begin
            spec_res = {s_ab, 31'b0};
        end
    end

    logic [SIG_W-1:0]  sig;
    logic signed [9:0] en;
    logic              inc;
    logic [SIG_W:0]    rnd;
    logic [MAN_W-1:0]  man;
    logic              n_ovf, n_unf;
    logic [31:0]       norm_res;
`ifdef FP_MULT_RNE_EN
    logic              guard, sticky;
`endif

    always_comb begin
        if (prod[47]) begin
            sig = prod[47:24];
            en  = e_q + 10'sd1;
        end else begin
            sig = prod[46:23];
            en  = e_q;
        end
`ifdef FP_MULT_RNE_EN
        guard  = prod[47] ? prod[23] : prod[22];
        sticky = prod[47] ? |prod[22:0] : |prod[21:0];
        inc    = guard & (sticky | sig[0]);
`else
        inc    = 1'b0;
`endif
        rnd = {1'b0, sig} + {{SIG_W{1'b0}}, inc};
        if (rnd[SIG_W]) begin
            man = rnd[SIG_W-1:1];
            en  = en + 10'sd1;
        end else begin
            man = rnd[MAN_W-1:0];
        end
        n_ovf = en >= 10'sd255;
        n_unf = !n_ovf && (en <= 10'sd0);
        if (n_ovf) begin
            norm_res = {sign_q, EXP_MAX, 23'b0};
        end else if (n_unf) begin
            norm_res = {sign_q, 31'b0};
        end else begin
            norm_res = {sign_q, en[7:0], man};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = EXP;
            EXP:  state_d = special ? DONE : MUL;
            MUL:  if (mul_done) state_d = NORM;
            NORM: state_d = DONE;
            DONE: if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // out_valid is registered, so it trails entry into DONE by one cycle.
    always_comb begin
        in_ready    = state_q == IDLE;
        busy        = state_q != IDLE;
        mul_start   = (state_q == EXP) && !special;
        out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            e_q         <= '0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            e_q         <= e_d;
            sign_q      <= sign_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        e_d      = e_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d = a;
                    b_d = b;
                end
            end
            EXP: begin
                sign_d = s_ab;
                e_d    = $signed({1'b0, exp_cout, exp_sum}) - BIAS_S;
                if (special) begin
                    result_d = spec_res;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                end
            end
            NORM: begin
                result_d = norm_res;
                ovf_d    = n_ovf;
                unf_d    = n_unf;
            end
            default: ;
        endcase
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_fp_mult_seq.sv
// Directed-vector bench for fp_mult_seq: table of operations plus handshake/reset sequences.
module tb_fp_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_mult_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int          lat;
        string       name;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int n;
        bit got;
        @(negedge clk);
        a        = v.a;
        b        = v.b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({v.name, "_busy"}, 32'(busy), 32'd1);
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) got = 1'b1;
        end
        chk({v.name, "_lat"}, 32'(n), 32'(v.lat));
        chk({v.name, "_res"}, result, v.res);
        chk({v.name, "_ovf"}, 32'(ovf), 32'(v.ovf));
        chk({v.name, "_unf"}, 32'(unf), 32'(v.unf));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({v.name, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vt[10];
    vec_t hv;

    initial begin
        int rises;
`ifdef FP_MULT_RNE_EN
        logic [31:0] rne_exp = 32'h3FC00002;
`else
        logic [31:0] rne_exp = 32'h3FC00001;
`endif
        vt[0] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 27, "one_one"};
        vt[1] = '{32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 27, "two_three"};
        vt[2] = '{32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0, 2,  "zero_neg"};
        vt[3] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 27, "overflow"};
        vt[4] = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 27, "underflow"};
        vt[5] = '{32'h3F800001, 32'h3FC00000, rne_exp,      1'b0, 1'b0, 27, "round"};
        vt[6] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 2,  "inf_zero"};
        vt[7] = '{32'hBFC00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0, 27, "neg_prod"};
        vt[8] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 1'b0, 2,  "inf_neg"};
        vt[9] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0, 27, "renorm"};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {30'd0, ovf, unf}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(vt[i]);
        end

        // Consumer stalls: outputs freeze and new operands are refused.
        @(negedge clk);
        a        = 32'h40000000;
        b        = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rises = 0;
        while (!out_valid && rises < 100) begin
            @(posedge clk);
            #1;
            rises++;
        end
        chk("stall_lat", 32'(rises), 32'd27);
        a        = 32'h3F800000;
        b        = 32'h3F800000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_res", result, 32'h40C00000);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stall_release", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("stall_not_taken", 32'(busy), 32'd0);

        // Reset mid-multiply aborts without producing a result.
        @(negedge clk);
        a        = 32'h40000000;
        b        = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_idle", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", result, 32'd0);
        rises = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) rises++;
        end
        chk("abort_no_valid", 32'(rises), 32'd0);

        hv = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 27, "recover"};
        run_op(hv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
